// File: rtl/xc_sha256_msched_pkg.sv
// rtl/xc_sha256_msched_pkg.sv - shared SHA-256 constants and schedule state encoding
package xc_sha256_msched_pkg;

  localparam int SHA256_BLOCK_WORDS = 16;
  localparam int SHA256_SCHED_WORDS = 64;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_EMIT = 1'b1
  } msched_state_t;

  // Select codes for the xc_sha256 transform block.
  localparam logic [1:0] SS_SIG0  = 2'b00;
  localparam logic [1:0] SS_SIG1  = 2'b01;
  localparam logic [1:0] SS_BSIG0 = 2'b10;
  localparam logic [1:0] SS_BSIG1 = 2'b11;

endpackage

// File: rtl/xc_sha256.sv
// rtl/xc_sha256.sv - SHA-256 rotate/shift transform: sigma0, sigma1, Sigma0, Sigma1
import xc_sha256_msched_pkg::*;

module xc_sha256 (
  input  logic [31:0] rs1,
  input  logic [1:0]  ss,
  output logic [31:0] result
);

  logic [31:0] sig0;
  logic [31:0] sig1;
  logic [31:0] bsig0;
  logic [31:0] bsig1;

  assign sig0  = {rs1[6:0],  rs1[31:7]}  ^ {rs1[17:0], rs1[31:18]} ^ {3'b000, rs1[31:3]};
  assign sig1  = {rs1[16:0], rs1[31:17]} ^ {rs1[18:0], rs1[31:19]} ^ {10'b0, rs1[31:10]};
  assign bsig0 = {rs1[1:0],  rs1[31:2]}  ^ {rs1[12:0], rs1[31:13]} ^ {rs1[21:0], rs1[31:22]};
  assign bsig1 = {rs1[5:0],  rs1[31:6]}  ^ {rs1[10:0], rs1[31:11]} ^ {rs1[24:0], rs1[31:25]};

  always_comb begin
    result = sig0;
    case (ss)
      SS_SIG0:  result = sig0;
      SS_SIG1:  result = sig1;
      SS_BSIG0: result = bsig0;
      SS_BSIG1: result = bsig1;
      default:  result = sig0;
    endcase
  end

endmodule

// File: rtl/xc_sha256_msched.sv
// rtl/xc_sha256_msched.sv - SHA-256 message schedule: loads 16 words, streams W[0..63]
import xc_sha256_msched_pkg::*;

module xc_sha256_msched (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        abort,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [5:0]  out_idx,
  output logic        out_last,
  output logic        busy
);

  localparam logic [3:0] LAST_LOAD = 4'(SHA256_BLOCK_WORDS - 1);
  localparam logic [5:0] LAST_EMIT = 6'(SHA256_SCHED_WORDS - 1);

  msched_state_t state;
  msched_state_t state_nxt;
  logic [3:0]    lcnt;
  logic [5:0]    ecnt;
  logic [31:0]   win [SHA256_BLOCK_WORDS];
  logic [31:0]   sig0_w1;
  logic [31:0]   sig1_w14;
  logic [31:0]   w_next;
  logic          in_xfer;
  logic          out_xfer;

  xc_sha256 u_sig0 (
    .rs1    (win[1]),
    .ss     (SS_SIG0),
    .result (sig0_w1)
  );

  xc_sha256 u_sig1 (
    .rs1    (win[14]),
    .ss     (SS_SIG1),
    .result (sig1_w14)
  );

  assign w_next    = sig1_w14 + win[9] + sig0_w1 + win[0];

  assign in_ready  = (state == ST_LOAD);
  assign out_valid = (state == ST_EMIT);
  assign out_data  = win[0];
  assign out_idx   = ecnt;
  assign out_last  = out_valid && (ecnt == LAST_EMIT);
  assign busy      = (state == ST_EMIT) || (lcnt != 4'd0);

  // Abort suppresses both transfers, so nothing is stored or advanced that cycle.
  assign in_xfer   = in_valid && in_ready && !abort;
  assign out_xfer  = out_valid && out_ready && !abort;

  always_ff @(posedge g_clk) begin
    if (g_reset) state <= ST_LOAD;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_LOAD;
    end else begin
      case (state)
        ST_LOAD: if (in_xfer && lcnt == LAST_LOAD) state_nxt = ST_EMIT;
        ST_EMIT: if (out_xfer && ecnt == LAST_EMIT) state_nxt = ST_LOAD;
        default: state_nxt = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset || abort) begin
      lcnt <= 4'd0;
      ecnt <= 6'd0;
    end else begin
      if (in_xfer) begin
        lcnt <= lcnt + 4'd1;
        if (lcnt == LAST_LOAD) ecnt <= 6'd0;
      end
      if (out_xfer) ecnt <= ecnt + 6'd1;
    end
  end

  // Window carries no reset; its contents only matter once a full block is loaded.
  always_ff @(posedge g_clk) begin
    if (!g_reset) begin
      if (in_xfer) begin
        win[lcnt] <= in_data;
      end else if (out_xfer) begin
        for (int i = 0; i < SHA256_BLOCK_WORDS - 1; i++) win[i] <= win[i+1];
        win[SHA256_BLOCK_WORDS-1] <= w_next;
      end
    end
  end

endmodule

// File: tb/tb_xc_sha256_msched.sv
// tb/tb_xc_sha256_msched.sv - directed self-checking bench for xc_sha256_msched
module tb_xc_sha256_msched;

  logic        g_clk = 1'b0;
  logic        g_reset = 1'b1;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [5:0]  out_idx;
  logic        out_last;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] cur_blk [16];
  logic [31:0] exp_w   [64];
  logic [31:0] obs_w   [64];

  xc_sha256_msched dut (
    .g_clk     (g_clk),
    .g_reset   (g_reset),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 g_clk = ~g_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_model();
    for (int t = 0; t < 16; t++) exp_w[t] = cur_blk[t];
    for (int t = 16; t < 64; t++)
      exp_w[t] = s1(exp_w[t-2]) + exp_w[t-7] + s0(exp_w[t-15]) + exp_w[t-16];
  endtask

  task automatic rand_block();
    for (int i = 0; i < 16; i++) cur_blk[i] = $urandom;
    build_model();
  endtask

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"},  {31'b0, in_ready},  32'd1);
    check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_out_last"},  {31'b0, out_last},  32'd0);
    check({tag, "_out_idx"},   {26'b0, out_idx},   32'd0);
    check({tag, "_busy"},      {31'b0, busy},      32'd0);
  endtask

  // Push the first nwords of cur_blk; in_valid stays high afterwards when hold is set.
  task automatic load_block(input int nwords, input bit hold);
    for (int i = 0; i < nwords; i++) begin
      int n = 0;
      in_valid = 1'b1;
      in_data  = cur_blk[i];
      while (!in_ready && n < 200) begin
        step();
        n++;
      end
      if (!in_ready) check("load_timeout", {31'b0, in_ready}, 32'd1);
      check("load_out_valid", {31'b0, out_valid}, 32'd0);
      step();
    end
    if (!hold) in_valid = 1'b0;
    in_data = 32'hDEADBEEF;
    if (nwords == 16) check("first_valid_latency", {31'b0, out_valid}, 32'd1);
    if (nwords > 0) check("load_busy", {31'b0, busy}, 32'd1);
  endtask

  // Drain the schedule, stalling 5 cycles at stall_idx, returning before the transfer at stop_idx.
  task automatic emit_block(input int stall_idx, input int stop_idx);
    out_ready = 1'b1;
    for (int t = 0; t < 64; t++) begin
      int n = 0;
      while (!out_valid && n < 200) begin
        step();
        n++;
      end
      if (!out_valid) begin
        check("emit_timeout", {31'b0, out_valid}, 32'd1);
        return;
      end
      obs_w[t] = out_data;
      check($sformatf("idx_%0d", t),  {26'b0, out_idx},  t);
      check($sformatf("w_%0d", t),    out_data,          exp_w[t]);
      check($sformatf("last_%0d", t), {31'b0, out_last}, (t == 63) ? 32'd1 : 32'd0);
      check("emit_in_ready", {31'b0, in_ready}, 32'd0);
      if (t == stall_idx) begin
        out_ready = 1'b0;
        repeat (5) begin
          step();
          check("stall_valid", {31'b0, out_valid}, 32'd1);
          check("stall_idx",   {26'b0, out_idx},   t);
          check("stall_data",  out_data,           exp_w[t]);
          check("stall_last",  {31'b0, out_last},  32'd0);
        end
        out_ready = 1'b1;
      end
      if (t == stop_idx) return;
      step();
    end
    check("post_emit_in_ready",  {31'b0, in_ready},  32'd1);
    check("post_emit_out_valid", {31'b0, out_valid}, 32'd0);
    check("post_emit_busy",      {31'b0, busy},      32'd0);
  endtask

  initial begin
    repeat (2) step();
    g_reset = 1'b0;
    check_idle("reset");

    // "abc" padded block
    for (int i = 0; i < 16; i++) cur_blk[i] = 32'h0;
    cur_blk[0]  = 32'h61626380;
    cur_blk[15] = 32'h00000018;
    build_model();
    load_block(16, 1'b0);
    emit_block(-1, -1);
    check("abc_w16", obs_w[16], 32'h61626380);
    check("abc_w17", obs_w[17], 32'h000F0000);

    // all-ones block
    for (int i = 0; i < 16; i++) cur_blk[i] = 32'hFFFFFFFF;
    build_model();
    load_block(16, 1'b0);
    emit_block(-1, -1);
    check("ones_w16", obs_w[16], 32'h203FFFFC);
    check("ones_w0",  obs_w[0],  32'hFFFFFFFF);
    check("ones_w15", obs_w[15], 32'hFFFFFFFF);

    // backpressure at idx 20
    rand_block();
    load_block(16, 1'b0);
    emit_block(20, -1);

    // reset after 7 input words, then a fresh block
    rand_block();
    load_block(7, 1'b0);
    g_reset = 1'b1;
    step();
    g_reset = 1'b0;
    check_idle("rst_load");
    rand_block();
    load_block(16, 1'b0);
    emit_block(-1, -1);

    // reset coincident with a transfer at idx 40
    rand_block();
    load_block(16, 1'b0);
    emit_block(-1, 40);
    g_reset = 1'b1;
    step();
    g_reset = 1'b0;
    check_idle("rst_emit");
    rand_block();
    load_block(16, 1'b0);
    emit_block(-1, -1);

    // abort coincident with a transfer at idx 10
    rand_block();
    load_block(16, 1'b0);
    emit_block(-1, 10);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle("abort");
    rand_block();
    load_block(16, 1'b0);
    emit_block(-1, -1);

    // back-to-back blocks with in_valid held high throughout
    rand_block();
    load_block(16, 1'b1);
    emit_block(-1, -1);
    rand_block();
    load_block(16, 1'b1);
    emit_block(-1, -1);
    in_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/xc_sha256_msched.md
XC_SHA256_MSCHED -- requirements
Module: xc_sha256_msched

Interface
REQ-001 Parameters: none; all sizes are fixed by SHA-256: 16-word block, 64 schedule words.
REQ-002 g_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 g_reset  input  1  reset; synchronous, active-high.
REQ-004 abort  input  1  synchronous cancel of the current block.
REQ-005 in_valid  input  1  in_data holds a message word.
REQ-006 in_ready  output  1  block accepts in_data this cycle.
REQ-007 in_data  input  32  message word, big-endian word order, W0 first.
REQ-008 out_valid  output  1  out_data holds schedule word W[out_idx].
REQ-009 out_ready  input  1  consumer accepts out_data this cycle.
REQ-010 out_data  output  32  schedule word W[t].
REQ-011 out_idx  output  6  t, 0..63.
REQ-012 out_last  output  1  high when out_valid is high and out_idx==63.
REQ-013 busy  output  1  high in EMIT, or in LOAD with load count nonzero.

Function
REQ-014 States: LOAD and EMIT. There are 4-bit load count lcnt, 6-bit emit count ecnt, and a 16x32 window win[0..15].
REQ-015 LOAD: in_ready=1 and out_valid=0; each in_valid&in_ready transfer writes in_data to win[lcnt] and increments lcnt.
REQ-016 LOAD transfer with lcnt==15: lcnt wraps to 0, ecnt:=0, next state EMIT; out_valid is first high the following cycle (1-cycle latency).
REQ-017 EMIT: in_ready=0, out_valid=1, out_data=win[0], out_idx=ecnt.
REQ-018 EMIT transfer (out_valid&out_ready):
  - win[i] := win[i+1] for i=0..14.
  - win[15] := sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], computed mod 2^32 with carries discarded.
  - ecnt increments.
REQ-019 sigma0(x) = ror7^ror18^shr3; sigma1(x) = ror17^ror19^shr10.
REQ-020 The next word is combinational from the window; one word per cycle is sustained while out_ready=1.
REQ-021 EMIT transfer with ecnt==63: next state LOAD, ecnt wraps to 0, in_ready is high the following cycle.
REQ-022 Backpressure: while out_valid=1 and out_ready=0, out_data, out_idx and out_last stay stable and the window does not change.
REQ-023 in_valid in EMIT is ignored; no word is consumed.
REQ-024 abort=1: next state LOAD, lcnt:=0, ecnt:=0. Abort has priority over a same-cycle input or output transfer. That transfer counts as not performed: the word is neither stored nor advanced. Window contents are don't-care after abort.
REQ-025 Words computed into win[15] during t>=48 are never emitted; they are don't-care.

Reset
REQ-026 g_reset=1 at a clock edge, in any state (including mid-LOAD or mid-EMIT), sets:
  - state=LOAD, lcnt=0, ecnt=0;
  - outputs in_ready=1, out_valid=0, out_last=0, out_idx=0, busy=0.
REQ-027 out_data is driven from win[0]; out_data is don't-care while out_valid=0. The window needs no reset.
REQ-028 g_reset has priority over abort and over all transfers.

Structure
REQ-029 Constants SHA256_BLOCK_WORDS=16 and SHA256_SCHED_WORDS=64, plus the state encoding, live in the shared SHA-256 header/package.
REQ-030 sigma0/sigma1 are produced by two instances of the existing xc_sha256 transform block: one with ss=2'b00 (input win[1]) and one with ss=2'b01 (input win[14]). No duplicate rotate logic.
REQ-031 The four-operand addition is a plain 32-bit adder chain; no pipelining.

Verification
REQ-032 "abc" padded block: W0=0x61626380, W1..W14=0, W15=0x00000018, out_ready=1.
  - Required: 64 outputs, out_idx 0..63 in order.
  - W16=0x61626380, W17=0x000F0000.
  - out_last only on idx 63.
  - First out_valid exactly 1 cycle after the 16th input transfer.
REQ-033 All-ones block (16x 0xFFFFFFFF) -> W16=0x203FFFFC; W0..W15 re-emitted unchanged.
REQ-034 out_ready held low 5 cycles at idx 20 -> out_data/out_idx stable throughout; then idx 21 follows with no skip or duplicate.
REQ-035 g_reset pulse after 7 input words, then a full fresh block -> outputs match that fresh block alone. Repeat with reset at idx 40 of EMIT.
REQ-036 abort coincident with an out transfer at idx 10 -> next cycle in LOAD, busy=0, in_ready=1, out_valid=0.
REQ-037 Two blocks back-to-back, in_valid held high -> second block's first word is accepted the cycle after idx-63 transfer; no input is accepted during EMIT.
